top_sort_display: RTL and testbench

- Classification result stage.
- Loads ten signed 16-bit scores packed in one 160-bit word and sorts them in descending order with an iterative odd-even transposition sorter.
- Reports the original position (0-9) of the largest score.
- Drives that digit onto a 7-segment display.
- Sits after the final network layer, ahead of board I/O.

---
 rtl/sort_pkg.sv | 29 ++
 rtl/seg7_decoder.sv | 26 ++
 rtl/top_sort_display.sv | 130 +++++++++++++
 tb/tb_top_sort_display.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared constants, segment patterns and state type for the sort/display stage
package sort_pkg;

    localparam int N     = 10;
    localparam int W     = 16;
    localparam int IDXW  = 4;
    localparam int PASSW = 4;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SORT,
        ST_DONE
    } sort_state_e;

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational digit to 7-segment map, blank above 9
module seg7_decoder
    import sort_pkg::*;
(
    input  logic [IDXW-1:0] digit,
    output logic [6:0]      seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/top_sort_display.sv
// rtl/top_sort_display.sv - odd-even transposition sort of ten scores, argmax to 7-segment
module top_sort_display
    import sort_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N*W-1:0]    data,
    input  logic              load,
    output logic              complete,
    output logic [IDXW-1:0]   index,
    output logic [N*W-1:0]    data_out,
    output logic [6:0]        display
);

    sort_state_e state_q, state_nxt;

    logic signed [W-1:0] val_q   [N];
    logic signed [W-1:0] val_nxt [N];
    logic [IDXW-1:0]     tag_q   [N];
    logic [IDXW-1:0]     tag_nxt [N];
    logic [PASSW-1:0]    pass_q;
    logic [N-1:0]        swap_r;
    logic [N-1:0]        swap_l;
    logic [6:0]          seg_w;

    // Pair (g,g+1) is active when its left index parity matches the pass parity
    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_pair
            if (g < N - 1) begin : g_right
                assign swap_r[g] = (pass_q[0] == 1'(g % 2)) && (val_q[g+1] > val_q[g]);
            end else begin : g_last
                assign swap_r[g] = 1'b0;
            end
            if (g > 0) begin : g_left
                assign swap_l[g] = swap_r[g-1];
            end else begin : g_first
                assign swap_l[g] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < N; i++) begin
            val_nxt[i] = val_q[i];
            tag_nxt[i] = tag_q[i];
        end
        for (int i = 0; i < N - 1; i++) begin
            if (swap_r[i]) begin
                val_nxt[i] = val_q[i+1];
                tag_nxt[i] = tag_q[i+1];
            end
        end
        for (int i = 1; i < N; i++) begin
            if (swap_l[i]) begin
                val_nxt[i] = val_q[i-1];
                tag_nxt[i] = tag_q[i-1];
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE: if (load) state_nxt = ST_LOAD;
            ST_LOAD: if (!load) state_nxt = ST_SORT;
            ST_SORT: begin
                if (load)
                    state_nxt = ST_LOAD;
                else if (pass_q == PASSW'(N - 1))
                    state_nxt = ST_DONE;
            end
            ST_DONE: if (load) state_nxt = ST_LOAD;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_nxt;
    end

    seg7_decoder u_seg7 (
        .digit (tag_q[0]),
        .seg   (seg_w)
    );

    // Any sampled load captures, so the last sampled word wins from every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            pass_q   <= '0;
            complete <= 1'b0;
            index    <= '0;
            data_out <= '0;
            display  <= SEG_BLANK;
        end else if (load) begin
            for (int i = 0; i < N; i++) begin
                val_q[i] <= data[W*i +: W];
                tag_q[i] <= IDXW'(i);
            end
            pass_q   <= '0;
            complete <= 1'b0;
        end else begin
            case (state_q)
                ST_SORT: begin
                    for (int i = 0; i < N; i++) begin
                        val_q[i] <= val_nxt[i];
                        tag_q[i] <= tag_nxt[i];
                    end
                    pass_q <= pass_q + PASSW'(1);
                end
                ST_DONE: begin
                    complete <= 1'b1;
                    index    <= tag_q[0];
                    display  <= seg_w;
                    for (int i = 0; i < N; i++)
                        data_out[W*i +: W] <= val_q[i];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_top_sort_display.sv
// tb/tb_top_sort_display.sv - directed vectors for the sort/display stage
module tb_top_sort_display;

    logic         clk;
    logic         rst_n;
    logic [159:0] data;
    logic         load;
    logic         complete;
    logic [3:0]   index;
    logic [159:0] data_out;
    logic [6:0]   display;

    int n_vec = 0;
    int n_err = 0;

    logic [159:0] d_mixed;
    logic [159:0] d_asc;
    logic [159:0] d_sorted;
    logic [159:0] d_sgn;
    logic [159:0] d_sgn_exp;
    logic [159:0] d_tie;

    top_sort_display dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data     (data),
        .load     (load),
        .complete (complete),
        .index    (index),
        .data_out (data_out),
        .display  (display)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [159:0] d, input int hold);
        data = d;
        load = 1'b1;
        repeat (hold) @(negedge clk);
        load = 1'b0;
    endtask

    // Counts edges after the first edge that samples load=0 until complete
    task automatic wait_done(input string tag, input int already);
        int cyc;
        cyc = already;
        while (!complete && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk(tag, 160'(cyc - 1), 160'd11);
    endtask

    initial begin
        d_mixed  = 160'h0006_0008_0007_0000_0005_0009_0003_0002_0001_0004;
        d_asc    = 160'h0009_0008_0007_0006_0005_0004_0003_0002_0001_0000;
        d_sorted = 160'h0000_0001_0002_0003_0004_0005_0006_0007_0008_0009;
        for (int i = 0; i < 10; i++) begin
            d_sgn[16*i +: 16]     = (i == 3) ? 16'hFFFF : 16'h8000;
            d_sgn_exp[16*i +: 16] = (i == 0) ? 16'hFFFF : 16'h8000;
            d_tie[16*i +: 16]     = 16'h0005;
        end

        rst_n = 1'b0;
        load  = 1'b0;
        data  = '0;
        #12;
        chk("rst_complete", 160'(complete), 160'd0);
        chk("rst_index",    160'(index),    160'd0);
        chk("rst_data_out", data_out,       160'd0);
        chk("rst_display",  160'(display),  160'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        load_word(d_mixed, 2);
        wait_done("mixed_latency", 0);
        chk("mixed_complete", 160'(complete), 160'd1);
        chk("mixed_index",    160'(index),    160'd4);
        chk("mixed_display",  160'(display),  160'(7'b1100110));
        chk("mixed_data_out", data_out,       d_sorted);

        @(negedge clk);
        load_word(d_asc, 2);
        repeat (3) @(negedge clk);
        chk("hold_complete", 160'(complete), 160'd0);
        chk("hold_index",    160'(index),    160'd4);
        wait_done("asc_latency", 3);
        chk("asc_index",    160'(index),   160'd9);
        chk("asc_display",  160'(display), 160'(7'b1101111));
        chk("asc_data_out", data_out,      d_sorted);

        @(negedge clk);
        load_word(d_sgn, 2);
        wait_done("sgn_latency", 0);
        chk("sgn_index",    160'(index),         160'd3);
        chk("sgn_elem0",    160'(data_out[15:0]), 160'h FFFF);
        chk("sgn_data_out", data_out,             d_sgn_exp);
        chk("sgn_display",  160'(display),       160'(7'b1001111));

        @(negedge clk);
        load_word(d_tie, 2);
        wait_done("tie_latency", 0);
        chk("tie_index",    160'(index),   160'd0);
        chk("tie_display",  160'(display), 160'(7'b0111111));
        chk("tie_data_out", data_out,      d_tie);

        @(negedge clk);
        load_word(d_mixed, 1);
        repeat (6) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_complete", 160'(complete), 160'd0);
        chk("midrst_index",    160'(index),    160'd0);
        chk("midrst_data_out", data_out,       160'd0);
        chk("midrst_display",  160'(display),  160'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        load_word(d_asc, 1);
        repeat (4) @(negedge clk);
        load_word(d_mixed, 1);
        wait_done("abort_latency", 0);
        chk("abort_index",    160'(index), 160'd4);
        chk("abort_data_out", data_out,    d_sorted);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
